// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith/compare/shift ops plus optional
// iterative unsigned MUL/DIVU, enabled by defining ALU_MULDIV_EN.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] ALUResultHi,
   output logic             Zero,
   output logic             Overflow,
   output logic             IllegalOp
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;

`ifdef ALU_MULDIV_EN
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
   typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [WIDTH-1:0] result_hi_reg, result_hi_next;
   logic             zero_reg, zero_next;
   logic             ovf_reg, ovf_next;
   logic             ill_reg, ill_next;

   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf, sc_ill;
   logic [WIDTH-1:0] sum_add, sum_sub;
   logic [SHW-1:0]   sh;

`ifdef ALU_MULDIV_EN
   // hi/lo double as {partial product, multiplier} or {remainder, quotient}
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic [WIDTH-1:0] opnd_reg, opnd_next;
   logic             div_reg, div_next;
   logic [SHW-1:0]   cnt_reg, cnt_next;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             is_muldiv;
`endif

   assign InReady     = (state_reg == IDLE);
   assign OutValid    = (state_reg == DONE);
   assign ALUResult   = result_reg;
   assign ALUResultHi = result_hi_reg;
   assign Zero        = zero_reg;
   assign Overflow    = ovf_reg;
   assign IllegalOp   = ill_reg;

   always_comb begin
      sc_res  = '0;
      sc_ovf  = 1'b0;
      sc_ill  = 1'b0;
      sh      = B[SHW-1:0];
      sum_add = A + B;
      sum_sub = A - B;
      case (ALUControl)
         OP_AND:  sc_res = A & B;
         OP_OR:   sc_res = A | B;
         OP_XOR:  sc_res = A ^ B;
         OP_NOR:  sc_res = ~(A | B);
         OP_ADD: begin
            sc_res = sum_add;
            sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = sum_sub;
            sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL:  sc_res = A << sh;
         OP_SRL:  sc_res = A >> sh;
         OP_SRA:  sc_res = $signed(A) >>> sh;
         default: sc_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   always_comb begin
      is_muldiv = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU);
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      div_shift = {hi_reg, lo_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_reg};
      if (div_reg) begin
         // Restoring step: a borrow in the top bit means the trial subtract failed
         if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_reg[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
      end
   end
`endif

   always_comb begin
      state_next     = state_reg;
      result_next    = result_reg;
      result_hi_next = result_hi_reg;
      zero_next      = zero_reg;
      ovf_next       = ovf_reg;
      ill_next       = ill_reg;
`ifdef ALU_MULDIV_EN
      hi_next        = hi_reg;
      lo_next        = lo_reg;
      opnd_next      = opnd_reg;
      div_next       = div_reg;
      cnt_next       = cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (InValid) begin
`ifdef ALU_MULDIV_EN
               if (is_muldiv) begin
                  hi_next    = '0;
                  lo_next    = A;
                  opnd_next  = B;
                  div_next   = (ALUControl == OP_DIVU);
                  cnt_next   = SHW'(WIDTH - 1);
                  state_next = CALC;
               end else
`endif
               begin
                  result_next    = sc_res;
                  result_hi_next = '0;
                  zero_next      = (sc_res == '0);
                  ovf_next       = sc_ovf;
                  ill_next       = sc_ill;
                  state_next     = DONE;
               end
            end
         end
`ifdef ALU_MULDIV_EN
         CALC: begin
            hi_next = step_hi;
            lo_next = step_lo;
            if (cnt_reg == '0) begin
               result_next    = step_lo;
               result_hi_next = step_hi;
               zero_next      = (step_lo == '0);
               ovf_next       = 1'b0;
               ill_next       = 1'b0;
               state_next     = DONE;
            end else begin
               cnt_next = cnt_reg - SHW'(1);
            end
         end
`endif
         DONE: begin
            if (OutReady) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg     <= IDLE;
         result_reg    <= '0;
         result_hi_reg <= '0;
         zero_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         ill_reg       <= 1'b0;
`ifdef ALU_MULDIV_EN
         hi_reg        <= '0;
         lo_reg        <= '0;
         opnd_reg      <= '0;
         div_reg       <= 1'b0;
         cnt_reg       <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         result_reg    <= result_next;
         result_hi_reg <= result_hi_next;
         zero_reg      <= zero_next;
         ovf_reg       <= ovf_next;
         ill_reg       <= ill_next;
`ifdef ALU_MULDIV_EN
         hi_reg        <= hi_next;
         lo_reg        <= lo_next;
         opnd_reg      <= opnd_next;
         div_reg       <= div_next;
         cnt_reg       <= cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle (WIDTH = 32); adapts its
// MUL/DIVU expectations to whether ALU_MULDIV_EN is defined.
module tb_alu_multicycle;

   localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
   localparam bit MD_EN  = 1'b1;
   localparam int MD_LAT = WIDTH + 1;
`else
   localparam bit MD_EN  = 1'b0;
   localparam int MD_LAT = 1;
`endif

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic             InValid = 1'b0;
   logic             InReady;
   logic [3:0]       ALUControl = 4'b0000;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             OutValid;
   logic             OutReady = 1'b0;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] ALUResultHi;
   logic             Zero;
   logic             Overflow;
   logic             IllegalOp;

   alu_multicycle #(.WIDTH(WIDTH)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
      .ALUControl(ALUControl), .A(A), .B(B), .OutValid(OutValid),
      .OutReady(OutReady), .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
      .Zero(Zero), .Overflow(Overflow), .IllegalOp(IllegalOp)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] hi;
      logic             ovf;
      logic             ill;
      logic             zero;
      int               lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic [31:0] hi,
                               input logic ovf, input logic ill, input logic zero, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi;
      v.ovf = ovf; v.ill = ill; v.zero = zero; v.lat = lat;
      return v;
   endfunction

   // Reserved-style response used for 1101..1111 and for MUL/DIVU when disabled
   function automatic vec_t mk_ill(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      return mk(op, a, b, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
   endfunction

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, "_valid"},    64'(OutValid),    64'(1));
      check({tag, "_inready"},  64'(InReady),     64'(0));
      check({tag, "_result"},   64'(ALUResult),   64'(v.res));
      check({tag, "_resulthi"}, 64'(ALUResultHi), 64'(v.hi));
      check({tag, "_overflow"}, 64'(Overflow),    64'(v.ovf));
      check({tag, "_illegal"},  64'(IllegalOp),   64'(v.ill));
      check({tag, "_zero"},     64'(Zero),        64'(v.zero));
   endtask

   // Accept one op and wait (bounded) for OutValid; returns cycles from acceptance edge
   task automatic issue(input vec_t v, output int cycles);
      int n;
      n = 0;
      @(negedge Clk);
      while (!InReady && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check("inready_before_issue", 64'(InReady), 64'(1));
      InValid = 1'b1; ALUControl = v.op; A = v.a; B = v.b;
      @(posedge Clk);
      #1;
      InValid = 1'b0; ALUControl = 4'b0010; A = 32'hDEADBEEF; B = 32'h13579BDF;
      cycles = 1;
      @(negedge Clk);
      while (!OutValid && cycles < 100) begin
         if (InReady) begin
            errors++;
            checks++;
            $display("FAIL busy_inready: got 1, expected 0 at cycle %0d", cycles);
         end
         @(negedge Clk);
         cycles++;
      end
   endtask

   task automatic release_out();
      OutReady = 1'b1;
      @(posedge Clk);
      #1;
      OutReady = 1'b0;
      check("post_handshake_outvalid", 64'(OutValid), 64'(0));
      check("post_handshake_inready",  64'(InReady),  64'(1));
   endtask

   task automatic run_vec(input vec_t v);
      int cyc;
      issue(v, cyc);
      $display("txn op=%b a=%h b=%h -> res=%h hi=%h ovf=%0b ill=%0b zero=%0b lat=%0d",
               v.op, v.a, v.b, ALUResult, ALUResultHi, Overflow, IllegalOp, Zero, cyc);
      check("latency", 64'(cyc), 64'(v.lat));
      check_outputs("vec", v);
      release_out();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_inready"},  64'(InReady),     64'(1));
      check({tag, "_outvalid"}, 64'(OutValid),    64'(0));
      check({tag, "_result"},   64'(ALUResult),   64'(0));
      check({tag, "_resulthi"}, 64'(ALUResultHi), 64'(0));
      check({tag, "_zero"},     64'(Zero),        64'(0));
      check({tag, "_overflow"}, 64'(Overflow),    64'(0));
      check({tag, "_illegal"},  64'(IllegalOp),   64'(0));
   endtask

   initial begin
      int   cyc;
      vec_t v;
      bit   saw_valid;

      vecs.push_back(mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0, 1)); // ADD ovf
      vecs.push_back(mk(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0, 1, 1)); // ADD carry only
      vecs.push_back(mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 0, 0, 0, 1, 1)); // SUB zero
      vecs.push_back(mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0, 0, 1)); // SUB ovf
      vecs.push_back(mk(4'b0110, 32'h00000000, 32'h80000000, 32'h80000000, 0, 1, 0, 0, 1)); // SUB ovf
      vecs.push_back(mk(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1)); // SLT
      vecs.push_back(mk(4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0, 1, 1)); // SLTU
      vecs.push_back(mk(4'b1010, 32'h80000000, 32'h00000023, 32'hF0000000, 0, 0, 0, 0, 1)); // SRA
      vecs.push_back(mk(4'b1001, 32'h80000000, 32'h00000024, 32'h08000000, 0, 0, 0, 0, 1)); // SRL
      vecs.push_back(mk(4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 0, 1)); // SLL by 31
      vecs.push_back(mk(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1)); // AND
      vecs.push_back(mk(4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 0, 0, 0, 0, 1)); // OR
      vecs.push_back(mk(4'b0011, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 0, 0, 0, 0, 1)); // XOR
      vecs.push_back(mk(4'b0100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1)); // NOR
      vecs.push_back(mk_ill(4'b1101, 32'h12345678, 32'h9ABCDEF0));
      vecs.push_back(mk_ill(4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF));
      vecs.push_back(mk_ill(4'b1111, 32'h00000001, 32'h00000001));
      if (MD_EN) begin
         vecs.push_back(mk(4'b1011, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 0, 0, 0, MD_LAT));
         vecs.push_back(mk(4'b1011, 32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 0, 0, 1, MD_LAT));
         vecs.push_back(mk(4'b1011, 32'h00001234, 32'h00000010, 32'h00012340, 32'h0, 0, 0, 0, MD_LAT));
         vecs.push_back(mk(4'b1100, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h7, 0, 0, 0, MD_LAT));
         vecs.push_back(mk(4'b1100, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h2, 0, 0, 0, MD_LAT));
         vecs.push_back(mk(4'b1100, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'hFFFF, 0, 0, 0, MD_LAT));
      end else begin
         vecs.push_back(mk_ill(4'b1011, 32'hFFFFFFFF, 32'h00000002));
         vecs.push_back(mk_ill(4'b1100, 32'h00000007, 32'h00000000));
      end

      // Reset held for two edges
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      check_reset_state("reset");

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: outputs hold and new requests are ignored while OutReady is low
      if (MD_EN) v = mk(4'b1011, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h1, 0, 0, 0, MD_LAT);
      else       v = mk(4'b0010, 32'h12345678, 32'h11111111, 32'h23456789, 32'h0, 0, 0, 0, 1);
      issue(v, cyc);
      $display("txn backpressure op=%b res=%h hi=%h lat=%0d", v.op, ALUResult, ALUResultHi, cyc);
      check("bp_latency", 64'(cyc), 64'(v.lat));
      InValid = 1'b1; ALUControl = 4'b0000; A = 32'h0; B = 32'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         check_outputs("bp_hold", v);
      end
      InValid = 1'b0;
      release_out();

      // Reset from DONE clears every output register
      v = mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0, 1);
      issue(v, cyc);
      $display("txn pre_reset op=%b res=%h ovf=%0b", v.op, ALUResult, Overflow);
      check("pre_reset_result", 64'(ALUResult), 64'(32'h80000000));
      @(negedge Clk);
      Rst_n = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      check_reset_state("reset_done");

      // Reset in the middle of a MUL discards it
      if (MD_EN) begin
         @(negedge Clk);
         InValid = 1'b1; ALUControl = 4'b1011; A = 32'hFFFFFFFF; B = 32'h00000003;
         @(posedge Clk);
         #1;
         InValid = 1'b0;
         repeat (9) @(posedge Clk);
         #1;
         check("midmul_busy", 64'(InReady), 64'(0));
         Rst_n = 1'b0;
         @(posedge Clk);
         #1;
         Rst_n = 1'b1;
         check_reset_state("reset_midmul");
         saw_valid = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (OutValid) saw_valid = 1'b1;
         end
         check("midmul_no_result", 64'(saw_valid), 64'(0));
         $display("txn midmul_reset result_emitted=%0b", saw_valid);
      end

      // Back-to-back ops still work after reset
      run_vec(mk(4'b0110, 32'h00000010, 32'h00000001, 32'h0000000F, 0, 0, 0, 0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
